// File: rtl/eth_tx_axis_fifo.sv
// eth_tx_axis_fifo
// Beat FIFO between an AXI-Stream source and the MAC TX input.
// Storage is a DEPTH-entry array. A registered first-word-fall-through
// output stage mirrors the head entry. The head keeps its array slot until
// it is read, so o_count counts the output register as one of the entries.
//
// Optional feature: define ETH_TX_STORE_FWD_EN for store-and-forward release.
// A frame is held back until its tlast beat is stored. If a single frame
// fills the whole FIFO without a tlast, that frame is released in
// cut-through mode and o_oversize pulses once.
//
// Handshake rule, both ports: a beat moves on a rising clock edge where
// valid and ready are both high. Valid is never withdrawn and the payload
// never changes until that edge.
module eth_tx_axis_fifo #(
    parameter int N_SYMBOLS = 8,
    parameter int W_SYMBOL  = 8,
    parameter int DEPTH     = 64
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic                                s_tvalid,
    output logic                                s_tready,
    input  logic [N_SYMBOLS*W_SYMBOL-1:0]       s_tdata,
    input  logic [N_SYMBOLS-1:0]                s_tkeep,
    input  logic                                s_tlast,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic [N_SYMBOLS*W_SYMBOL-1:0]       m_tdata,
    output logic [N_SYMBOLS-1:0]                m_tkeep,
    output logic                                m_tlast,
    output logic [$clog2(DEPTH+1)-1:0]          o_count,
    output logic                                o_oversize
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int DW = N_SYMBOLS * W_SYMBOL;
    localparam int EW = DW + N_SYMBOLS + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Each entry is stored as {tlast, tkeep, tdata}.
    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_after_rd;
    logic [CW-1:0] count_next;
    logic [EW-1:0] head_next;
    logic          wr_en;
    logic          rd_en;
    logic          gate_next;

    // Handshakes, next occupancy and the next head beat.
    always_comb begin
        wr_en          = s_tvalid && s_tready;
        rd_en          = m_tvalid && m_tready;
        rd_ptr_next    = rd_ptr + {{(AW-1){1'b0}}, rd_en};
        count_after_rd = o_count - {{(CW-1){1'b0}}, rd_en};
        count_next     = count_after_rd + {{(CW-1){1'b0}}, wr_en};
        // When nothing else remains after this cycle's read, the beat
        // written now becomes the head. It is bypassed straight into the
        // output register, which gives one-cycle latency into an empty FIFO.
        if (count_after_rd == '0) begin
            head_next = {s_tlast, s_tkeep, s_tdata};
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

`ifdef ETH_TX_STORE_FWD_EN
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] frame_cnt_next;
    logic          cut_mode;
    logic          cut_hold;
    logic          cut_next;
    logic          enter_cut;
    logic          wr_last;
    logic          rd_last;

    // Complete-frame count and the oversize (forced cut-through) decision.
    always_comb begin
        wr_last        = wr_en && s_tlast;
        rd_last        = rd_en && m_tlast;
        frame_cnt_next = frame_cnt + {{(CW-1){1'b0}}, wr_last}
                                   - {{(CW-1){1'b0}}, rd_last};
        // Cut-through for an oversize frame ends once that frame's tlast leaves.
        cut_hold       = cut_mode && !rd_last;
        // Cut-through starts when the array is full but holds no complete
        // frame. Without it the source and the MAC would wait on each other
        // forever.
        enter_cut      = !cut_hold && (count_next == DEPTH_C) && (frame_cnt_next == '0);
        cut_next       = cut_hold || enter_cut;
        gate_next      = (frame_cnt_next != '0) || cut_next;
    end

    // Frame counter, cut-through flag and the oversize pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame_cnt  <= '0;
            cut_mode   <= 1'b0;
            o_oversize <= 1'b0;
        end else begin
            frame_cnt  <= frame_cnt_next;
            cut_mode   <= cut_next;
            o_oversize <= enter_cut;
        end
    end
`else
    // Cut-through only: the head is released as soon as it is stored.
    always_comb begin
        gate_next = 1'b1;
    end

    assign o_oversize = 1'b0;
`endif

    // Pointers, occupancy, registered ready and the FWFT output stage.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            o_count  <= '0;
            s_tready <= 1'b0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tkeep  <= '0;
            m_tdata  <= '0;
        end else begin
            wr_ptr   <= wr_ptr + {{(AW-1){1'b0}}, wr_en};
            rd_ptr   <= rd_ptr_next;
            o_count  <= count_next;
            // Ready uses the post-update count, so a full FIFO refuses a
            // write even in a cycle where a read frees a slot.
            s_tready <= (count_next < DEPTH_C);
            m_tvalid <= (count_next != '0) && gate_next;
            // While the head is not read, this reloads the same entry,
            // so the outputs stay stable during back-pressure.
            if (count_next != '0) begin
                {m_tlast, m_tkeep, m_tdata} <= head_next;
            end
        end
    end

    // Array write port; a held-in-reset FIFO never asserts s_tready.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_tlast, s_tkeep, s_tdata};
        end
    end

endmodule

// File: tb/tb_eth_tx_axis_fifo.sv
// tb_eth_tx_axis_fifo
// Scoreboard bench for eth_tx_axis_fifo. The reference model is a queue of
// accepted beats plus the frame-release rule. The same bench covers both
// builds: it follows ETH_TX_STORE_FWD_EN when that macro is defined.
module tb_eth_tx_axis_fifo;

    localparam int N     = 8;
    localparam int W     = 8;
    localparam int DEPTH = 64;
    localparam int DW    = N * W;
    localparam int BW    = DW + N + 1;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef ETH_TX_STORE_FWD_EN
    localparam bit SF = 1'b1;
`else
    localparam bit SF = 1'b0;
`endif

    logic          i_clk;
    logic          i_reset_n;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] s_tdata;
    logic [N-1:0]  s_tkeep;
    logic          s_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic [N-1:0]  m_tkeep;
    logic          m_tlast;
    logic [CW-1:0] o_count;
    logic          o_oversize;

    eth_tx_axis_fifo #(.N_SYMBOLS(N), .W_SYMBOL(W), .DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .o_count    (o_count),
        .o_oversize (o_oversize)
    );

    // Clock and bookkeeping.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int ov_seen  = 0;
    bit drv_done = 1'b0;

    // Expected beats, {tlast, tkeep, tdata}, in the order they must leave.
    logic [BW-1:0] exp_q[$];
    bit cut_m    = 1'b0;
    bit ov_exp   = 1'b0;
    bit rst_prev = 1'b1;

    task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int tlasts_in_q();
        int c = 0;
        foreach (exp_q[i]) if (exp_q[i][BW-1]) c++;
        return c;
    endfunction

    // Monitor: at each falling edge, compare DUT state with the model, then
    // advance the model by the handshakes the next rising edge will perform.
    always @(negedge i_clk) begin
        logic [BW-1:0] popped;
        bit exp_valid;
        if (!i_reset_n) begin
            chk("rst_s_tready", s_tready, 0);
            chk("rst_m_tvalid", m_tvalid, 0);
            chk("rst_m_beat", {m_tlast, m_tkeep, m_tdata}, 0);
            chk("rst_o_count", o_count, 0);
            chk("rst_o_oversize", o_oversize, 0);
            exp_q.delete();
            cut_m    = 1'b0;
            ov_exp   = 1'b0;
            rst_prev = 1'b1;
        end else begin
            exp_valid = (exp_q.size() > 0) && (!SF || tlasts_in_q() > 0 || cut_m);
            chk("o_count", o_count, exp_q.size());
            chk("s_tready", s_tready, rst_prev ? 0 : (exp_q.size() < DEPTH));
            chk("m_tvalid", m_tvalid, exp_valid);
            chk("o_oversize", o_oversize, ov_exp);
            if (o_oversize) ov_seen++;
            rst_prev = 1'b0;
            if (m_tvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL m_beat: got %0h expected no beat at %0t",
                             {m_tlast, m_tkeep, m_tdata}, $time);
                end else begin
                    chk("m_beat", {m_tlast, m_tkeep, m_tdata}, exp_q[0]);
                    if (m_tready) begin
                        popped = exp_q.pop_front();
                        if (popped[BW-1]) cut_m = 1'b0;
                    end
                end
            end
            if (s_tvalid && s_tready) exp_q.push_back({s_tlast, s_tkeep, s_tdata});
            ov_exp = 1'b0;
            if (SF && !cut_m && exp_q.size() == DEPTH && tlasts_in_q() == 0) begin
                cut_m  = 1'b1;
                ov_exp = 1'b1;
            end
        end
    end

    // Driver: offer one beat and wait, with a time limit, until it is accepted.
    task automatic send_beat(input logic [DW-1:0] d, input logic [N-1:0] k, input logic l);
        bit acc;
        int n = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        do begin
            @(negedge i_clk);
            acc = s_tready;
            @(posedge i_clk);
            #1;
            n++;
        end while (!acc && n < 1000);
        s_tvalid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got no s_tready expected acceptance at %0t", $time);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Drain everything with the output always ready; report if it never empties.
    task automatic wait_drain();
        int n = 0;
        m_tready = 1'b1;
        while ((exp_q.size() != 0 || m_tvalid) && n < 2000) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0 || m_tvalid) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    endtask

    // Stimulus sequence.
    initial begin
        int len;
        i_reset_n = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        s_tkeep   = '0;
        s_tlast   = 1'b0;
        m_tready  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        idle(1);
        chk("s_tready_after_reset", s_tready, 1);

        // Single 3-beat frame with the output always ready.
        m_tready = 1'b1;
        send_beat(rnd_data(), 8'hFF, 1'b0);
        chk("t1_first_valid", m_tvalid, SF ? 0 : 1);
        send_beat(rnd_data(), 8'hFF, 1'b0);
        send_beat(rnd_data(), 8'h0F, 1'b1);
        chk("t1_valid_after_last", m_tvalid, 1);
        wait_drain();

        // Fill with the output stalled, then read once while the full FIFO is offered another beat.
        m_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_beat(rnd_data(), N'($urandom_range(0, 255)), 1'b0);
        chk("fill_s_tready", s_tready, 0);
        chk("fill_count", o_count, DEPTH);
        chk("fill_m_tvalid", m_tvalid, 1);
        s_tdata  = rnd_data();
        s_tkeep  = 8'hAA;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        idle(1);
        chk("full_rw_count", o_count, DEPTH - 1);
        chk("full_rw_s_tready", s_tready, 1);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        send_beat(rnd_data(), 8'hFF, 1'b1);
        wait_drain();

        // 5-beat frame with a long pause before tlast.
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(rnd_data(), 8'hFF, 1'b0);
        idle(2);
        for (int i = 0; i < 8; i++) begin
            idle(1);
            chk("gap_m_tvalid", m_tvalid, 0);
        end
        send_beat(rnd_data(), 8'h03, 1'b1);
        chk("t3_valid_after_last", m_tvalid, 1);
        wait_drain();

        // 70-beat frame: larger than the FIFO.
        ov_seen  = 0;
        m_tready = 1'b1;
        for (int i = 0; i < 70; i++) send_beat(rnd_data(), 8'hFF, i == 69);
        wait_drain();
        chk("t4_oversize_pulses", ov_seen, SF ? 1 : 0);

        // Random frames, random gaps and random back-pressure.
        drv_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    len = $urandom_range(1, 12);
                    for (int b = 0; b < len; b++)
                        send_beat(rnd_data(), N'($urandom_range(0, 255)), b == len - 1);
                    idle($urandom_range(0, 3));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge i_clk);
                    #1;
                    m_tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        wait_drain();

        // Reset after 2 of 4 beats, then send a full frame.
        m_tready = 1'b0;
        send_beat(rnd_data(), 8'hFF, 1'b0);
        send_beat(rnd_data(), 8'hFF, 1'b0);
        i_reset_n = 1'b0;
        idle(2);
        chk("t6_rst_count", o_count, 0);
        chk("t6_rst_m_tvalid", m_tvalid, 0);
        i_reset_n = 1'b1;
        idle(1);
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(rnd_data(), 8'hF0, i == 3);
        wait_drain();

        chk("final_queue_empty", exp_q.size(), 0);
        summary();
        $finish;
    end

    // Watchdog: report a stuck run and still end with the summary line.
    initial begin
        #1000000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: got no completion expected finish by %0t", $time);
        summary();
        $finish;
    end

endmodule
